uart_tx_arbiter: RTL and testbench

Session-level round-robin arbiter that shares the single UART transmitter between byte-stream producers: the matrix displayer, the menu/prompt printer and the error reporter. A producer raises `req`, receives an exclusive grant, streams any number of bytes through the `tx_start`/`tx_busy` handshake it already uses, then drops `req`. The arbiter sits between the producers and `uart_tx`. It adds a shadow-busy flag so producers never observe a false idle between their `tx_start` pulse and the UART raising `tx_busy`.

---
 rtl/uart_tx_arbiter_pkg.sv | 18 +
 rtl/uart_tx_arbiter_rr_priority_picker.sv | 36 +++
 rtl/uart_tx_arbiter.sv | 154 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, default
// requester count and the fixed requester IDs used across the codebase.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int N_REQ_DEF = 3;
  localparam int ID_W      = 3;

  localparam logic [ID_W-1:0] ID_DISP = 3'd0;
  localparam logic [ID_W-1:0] ID_MENU = 3'd1;
  localparam logic [ID_W-1:0] ID_ERR  = 3'd2;

endpackage

// File: rtl/uart_tx_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first asserted request found when
// scanning upward from ptr+1 (wrapping), returned one-hot and as an index.
module rr_priority_picker
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] win_o,
  output logic [ID_W-1:0]  idx_o,
  output logic             any_o
);

  always_comb begin
    int   pos;
    logic found;
    pos   = 0;
    found = 1'b0;
    win_o = '0;
    idx_o = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      pos = int'(ptr_i) + k;
      if (pos >= N_REQ) pos = pos - N_REQ;
      for (int j = 0; j < N_REQ; j++) begin
        if (!found && (j == pos) && req_i[j]) begin
          found    = 1'b1;
          win_o[j] = 1'b1;
          idx_o    = ID_W'(j);
        end
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Session-level round-robin owner of the single UART transmitter, with a
// shadow-busy flag covering the gap between a start strobe and UART busy.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int DW    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    req_tx_start,
  input  logic [N_REQ*DW-1:0] req_tx_data,
  output logic [N_REQ-1:0]    req_tx_busy,
  output logic [N_REQ-1:0]    gnt,
  output logic [2:0]          active_id,
  output logic                uart_tx_start,
  output logic [DW-1:0]       uart_tx_data,
  input  logic                uart_tx_busy,
  output logic                protocol_err
);

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic              pending_q, pending_d;
  logic              perr_q, perr_d;

  logic [N_REQ-1:0]  win;
  logic [ID_W-1:0]   win_idx;
  logic              win_any;

  logic              owner_req;
  logic              owner_start;
  logic [DW-1:0]     owner_data;
  logic              owner_busy;
  logic              fwd;
  logic              perr_set;
  logic [N_REQ-1:0]  busy_vec;

  rr_priority_picker #(
    .N_REQ (N_REQ)
  ) u_picker (
    .req_i (req),
    .ptr_i (ptr_q),
    .win_o (win),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  // Owner's lane selected by comparison to keep index widths exact.
  always_comb begin
    owner_req   = 1'b0;
    owner_start = 1'b0;
    owner_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (id_q == ID_W'(i)) begin
        owner_req   = req[i];
        owner_start = req_tx_start[i];
        owner_data  = req_tx_data[i*DW +: DW];
      end
    end
  end

  assign owner_busy = uart_tx_busy | pending_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q     <= '0;
      id_q      <= '0;
      ptr_q     <= ID_W'(N_REQ - 1);
      pending_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      gnt_q     <= gnt_d;
      id_q      <= id_d;
      ptr_q     <= ptr_d;
      pending_q <= pending_d;
      perr_q    <= perr_d;
    end
  end

  // A byte forwarded in the very cycle req drops still counts as in flight.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (win_any) begin
          state_d = ST_OWN;
          gnt_d   = win;
          id_d    = win_idx;
          ptr_d   = win_idx;
        end
      end
      ST_OWN: begin
        if (!owner_req) begin
          if (owner_busy || fwd) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            id_d    = '0;
          end
        end
      end
      ST_DRAIN: begin
        if (!owner_busy) begin
          state_d = ST_IDLE;
          gnt_d   = '0;
          id_d    = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        id_d    = '0;
      end
    endcase
  end

  always_comb begin
    fwd      = 1'b0;
    perr_set = 1'b0;
    busy_vec = '1;
    if (state_q == ST_OWN) begin
      fwd      = owner_start & ~owner_busy;
      perr_set = owner_start & owner_busy;
      for (int i = 0; i < N_REQ; i++) begin
        if (id_q == ID_W'(i)) busy_vec[i] = owner_busy;
      end
    end
    if (fwd)               pending_d = 1'b1;
    else if (uart_tx_busy) pending_d = 1'b0;
    else                   pending_d = pending_q;
    perr_d = perr_q | perr_set;
  end

  assign uart_tx_start = fwd;
  assign uart_tx_data  = fwd ? owner_data : '0;
  assign req_tx_busy   = busy_vec;
  assign gnt           = gnt_q;
  assign active_id     = id_q;
  assign protocol_err  = perr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple UART busy model.
module tb_uart_tx_arbiter;

  localparam int N  = 3;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  req_tx_start = '0;
  logic [N*DW-1:0] req_tx_data = '0;
  logic [N-1:0]  req_tx_busy;
  logic [N-1:0]  gnt;
  logic [2:0]    active_id;
  logic          uart_tx_start;
  logic [DW-1:0] uart_tx_data;
  logic          uart_tx_busy;
  logic          protocol_err;

  int errors = 0;
  int checks = 0;
  int gap_err = 0;
  int ucnt;
  logic tb_pend;
  logic [7:0] log_q[$];

  uart_tx_arbiter #(.N_REQ(N), .DW(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .req_tx_start  (req_tx_start),
    .req_tx_data   (req_tx_data),
    .req_tx_busy   (req_tx_busy),
    .gnt           (gnt),
    .active_id     (active_id),
    .uart_tx_start (uart_tx_start),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_busy  (uart_tx_busy),
    .protocol_err  (protocol_err)
  );

  always #5 clk = ~clk;

  // UART: busy rises 2 cycles after a start and lasts 10 cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)             ucnt <= 0;
    else if (uart_tx_start) ucnt <= 12;
    else if (ucnt > 0)      ucnt <= ucnt - 1;
  end
  assign uart_tx_busy = (ucnt >= 2) && (ucnt <= 11);

  always @(posedge clk) begin
    if (rst_n && uart_tx_start) log_q.push_back(uart_tx_data);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)             tb_pend <= 1'b0;
    else if (uart_tx_start) tb_pend <= 1'b1;
    else if (uart_tx_busy)  tb_pend <= 1'b0;
  end

  always @(negedge clk) begin
    if (rst_n && tb_pend && !uart_tx_busy && req_tx_busy !== 3'b111) gap_err++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req = '0;
    req_tx_start = '0;
    req_tx_data = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    log_q.delete();
  endtask

  task automatic wait_idle_busy(input logic [1:0] id, input string tag);
    int n;
    n = 0;
    while (req_tx_busy[id] !== 1'b0 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL %s_wait: req_tx_busy=%b, required bit %0d low within 200 cycles", tag, req_tx_busy, id);
    end
  endtask

  task automatic wait_gnt(input string tag);
    int n;
    n = 0;
    while (gnt === '0 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL %s_gnt_wait: gnt=%b, required nonzero within 200 cycles", tag, gnt);
    end
  endtask

  task automatic send(input logic [1:0] id, input logic [7:0] b);
    wait_idle_busy(id, "send");
    req_tx_data[int'(id)*8 +: 8] = b;
    req_tx_start[id] = 1'b1;
    tick();
    req_tx_start = '0;
    req_tx_data = '0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b required 000", gnt); end
    checks++; if (active_id !== 3'd0) begin errors++; $display("FAIL reset_active_id: got %0d required 0", active_id); end
    checks++; if (req_tx_busy !== 3'b111) begin errors++; $display("FAIL reset_busy: got %b required 111", req_tx_busy); end
    checks++; if (uart_tx_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b required 0", uart_tx_start); end
    checks++; if (uart_tx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h required 00", uart_tx_data); end
    checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b required 0", protocol_err); end
  endtask

  task automatic test_single_session();
    apply_reset();
    gap_err = 0;
    req = 3'b001;
    tick();
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL single_gnt: got %b required 001", gnt); end
    send(2'd0, 8'h31);
    checks++; if (req_tx_busy[0] !== 1'b1) begin errors++; $display("FAIL single_busy_after_start: got %b required 1", req_tx_busy[0]); end
    send(2'd0, 8'h20);
    send(2'd0, 8'h0A);
    wait_idle_busy(2'd0, "single_end");
    req = 3'b000;
    tick();
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL single_release: got %b required 000", gnt); end
    checks++;
    if (log_q.size() != 3) begin
      errors++; $display("FAIL single_count: got %0d bytes required 3", log_q.size());
    end else if (log_q[0] !== 8'h31 || log_q[1] !== 8'h20 || log_q[2] !== 8'h0A) begin
      errors++; $display("FAIL single_bytes: got %h %h %h required 31 20 0a", log_q[0], log_q[1], log_q[2]);
    end
    checks++; if (gap_err != 0) begin errors++; $display("FAIL single_busy_gap: got %0d false idles required 0", gap_err); end
  endtask

  task automatic run_session(input logic [1:0] id);
    wait_gnt("session");
    checks++;
    if (gnt !== (3'b001 << id) || active_id !== {1'b0, id}) begin
      errors++; $display("FAIL order_gnt: got gnt=%b id=%0d required gnt=%b id=%0d", gnt, active_id, 3'b001 << id, id);
    end
    send(id, 8'h40 + {6'd0, id});
    wait_idle_busy(id, "session_end");
    req[id] = 1'b0;
    tick();
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL order_gap: got gnt=%b required 000", gnt); end
  endtask

  task automatic test_contention();
    apply_reset();
    req = 3'b111;
    run_session(2'd0);
    run_session(2'd1);
    run_session(2'd2);
    req = 3'b101;
    run_session(2'd0);
    run_session(2'd2);
  endtask

  task automatic test_isolation();
    int cnt55;
    apply_reset();
    req = 3'b010;
    wait_gnt("iso");
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL iso_gnt: got %b required 010", gnt); end
    req_tx_data[23:16] = 8'h55;
    req_tx_start[2] = 1'b1;
    #1;
    checks++; if (uart_tx_start !== 1'b0 || uart_tx_data !== 8'h00) begin errors++; $display("FAIL iso_block: got start=%b data=%h required 0 00", uart_tx_start, uart_tx_data); end
    tick();
    req_tx_start = '0;
    req_tx_data = '0;
    send(2'd1, 8'hA5);
    req_tx_data[23:16] = 8'h55;
    req_tx_start[2] = 1'b1;
    tick();
    req_tx_start = '0;
    req_tx_data = '0;
    wait_idle_busy(2'd1, "iso_end");
    req = 3'b000;
    tick();
    checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL iso_perr: got %b required 0", protocol_err); end
    cnt55 = 0;
    foreach (log_q[i]) if (log_q[i] == 8'h55) cnt55++;
    checks++; if (cnt55 != 0 || log_q.size() != 1) begin errors++; $display("FAIL iso_log: got %0d bytes with %0d of 55 required 1 byte none 55", log_q.size(), cnt55); end
  endtask

  task automatic test_drain();
    int   n;
    logic hold_bad;
    apply_reset();
    req = 3'b001;
    wait_gnt("drain");
    send(2'd0, 8'h77);
    req = 3'b010;
    tick();
    checks++; if (gnt !== 3'b001 || req_tx_busy !== 3'b111) begin errors++; $display("FAIL drain_enter: got gnt=%b busy=%b required 001 111", gnt, req_tx_busy); end
    n = 0;
    hold_bad = 1'b0;
    while (!uart_tx_busy && n < 50) begin
      if (gnt !== 3'b001) hold_bad = 1'b1;
      tick(); n++;
    end
    while (uart_tx_busy && n < 50) begin
      if (gnt !== 3'b001) hold_bad = 1'b1;
      tick(); n++;
    end
    checks++; if (hold_bad || n >= 50) begin errors++; $display("FAIL drain_hold: got hold_bad=%b cycles=%0d required 0 and <50", hold_bad, n); end
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL drain_busy_fall: got %b required 001", gnt); end
    tick();
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL drain_clear: got %b required 000", gnt); end
    tick();
    checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL drain_next: got %b required 010", gnt); end
    req = 3'b000;
    repeat (3) tick();
  endtask

  task automatic test_protocol_err();
    apply_reset();
    req = 3'b001;
    wait_gnt("perr");
    req_tx_data[7:0] = 8'h11;
    req_tx_start[0] = 1'b1;
    #1;
    checks++; if (uart_tx_start !== 1'b1 || uart_tx_data !== 8'h11) begin errors++; $display("FAIL perr_first: got start=%b data=%h required 1 11", uart_tx_start, uart_tx_data); end
    tick();
    req_tx_data[7:0] = 8'h22;
    #1;
    checks++; if (uart_tx_start !== 1'b0) begin errors++; $display("FAIL perr_second_blocked: got %b required 0", uart_tx_start); end
    tick();
    req_tx_start = '0;
    req_tx_data = '0;
    checks++; if (protocol_err !== 1'b1) begin errors++; $display("FAIL perr_set: got %b required 1", protocol_err); end
    req = 3'b000;
    repeat (20) tick();
    checks++; if (protocol_err !== 1'b1) begin errors++; $display("FAIL perr_sticky: got %b required 1", protocol_err); end
    checks++; if (log_q.size() != 1 || log_q[0] !== 8'h11) begin errors++; $display("FAIL perr_log: got %0d bytes required 1 byte 11", log_q.size()); end
    rst_n = 1'b0;
    #1;
    checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL perr_reset: got %b required 0", protocol_err); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req = 3'b001;
    wait_gnt("rmid");
    send(2'd0, 8'h99);
    req_tx_data[7:0] = 8'h99;
    req_tx_start[0] = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL rmid_gnt: got %b required 000", gnt); end
    checks++; if (req_tx_busy !== 3'b111) begin errors++; $display("FAIL rmid_busy: got %b required 111", req_tx_busy); end
    checks++; if (uart_tx_start !== 1'b0 || uart_tx_data !== 8'h00) begin errors++; $display("FAIL rmid_start: got start=%b data=%h required 0 00", uart_tx_start, uart_tx_data); end
    checks++; if (active_id !== 3'd0) begin errors++; $display("FAIL rmid_id: got %0d required 0", active_id); end
    req_tx_start = '0;
    req_tx_data = '0;
    req = 3'b011;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL rmid_priority: got %b required 001", gnt); end
    req = 3'b000;
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_single_session();
    test_contention();
    checks++; if (gap_err != 0) begin errors++; $display("FAIL contention_busy_gap: got %0d false idles required 0", gap_err); end
    test_isolation();
    test_drain();
    test_protocol_err();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
